// File: rtl/ven_machine.sv
// Vending machine controller: newspaper, chocolate and juice with
// top-up credit, cancel/refund and registered change output.
module ven_machine #(
    parameter logic [4:0] PRICE_NEWS  = 5'd5,
    parameter logic [4:0] PRICE_CHOC  = 5'd10,
    parameter logic [4:0] PRICE_JUICE = 5'd15
) (
    input  logic       clock,
    input  logic       reset,
    output logic       news,
    output logic       choc,
    output logic       juice,
    output logic [4:0] balance,
    input  logic [4:0] money,
    input  logic [1:0] select_product,
    input  logic [4:0] extra_cash
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        WAIT_EXTRA,
        DISPENSE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] credit_q, credit_d;
    logic [1:0] product_q, product_d;
    logic [6:0] last_q, last_d;
    logic [4:0] prev_extra_q, prev_extra_d;
    logic [4:0] balance_q, balance_d;
    logic       news_q, news_d;
    logic       choc_q, choc_d;
    logic       juice_q, juice_d;

    logic [4:0] price;
    logic [5:0] topup_sum;
    logic [4:0] topup_sat;
    logic       accept;
    logic       enough;
    logic       topup_rise;
    logic       cancel;

    always_comb begin
        price = '0;
        case (product_q)
            2'b01:   price = PRICE_NEWS;
            2'b10:   price = PRICE_CHOC;
            2'b11:   price = PRICE_JUICE;
            default: price = '0;
        endcase
    end

    assign accept = (money != 5'd0) && (select_product != 2'b00) &&
                    ({money, select_product} != last_q);
    assign enough     = (credit_q >= price);
    assign cancel     = (select_product == 2'b00);
    assign topup_rise = (extra_cash != 5'd0) && (prev_extra_q == 5'd0);
    assign topup_sum  = {1'b0, credit_q} + {1'b0, extra_cash};
    assign topup_sat  = topup_sum[5] ? 5'd31 : topup_sum[4:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            product_q    <= '0;
            last_q       <= '0;
            prev_extra_q <= '0;
            balance_q    <= '0;
            news_q       <= 1'b0;
            choc_q       <= 1'b0;
            juice_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            product_q    <= product_d;
            last_q       <= last_d;
            prev_extra_q <= prev_extra_d;
            balance_q    <= balance_d;
            news_q       <= news_d;
            choc_q       <= choc_d;
            juice_q      <= juice_d;
        end
    end

    // DISPENSE also accepts, so a new request can land on the edge
    // that ends the product pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       state_d = accept ? EVAL : IDLE;
            EVAL:       state_d = enough ? DISPENSE : WAIT_EXTRA;
            WAIT_EXTRA: begin
                if (cancel)      state_d = IDLE;
                else if (enough) state_d = DISPENSE;
                else             state_d = WAIT_EXTRA;
            end
            DISPENSE:   state_d = accept ? EVAL : IDLE;
        endcase
    end

    always_comb begin
        credit_d     = credit_q;
        product_d    = product_q;
        last_d       = last_q;
        balance_d    = balance_q;
        prev_extra_d = extra_cash;
        news_d       = 1'b0;
        choc_d       = 1'b0;
        juice_d      = 1'b0;
        unique case (state_q)
            IDLE, DISPENSE: begin
                if (accept) begin
                    credit_d  = money;
                    product_d = select_product;
                    last_d    = {money, select_product};
                    balance_d = '0;
                end else if (money == 5'd0) begin
                    // Withdrawn money lets the same purchase be repeated.
                    last_d = '0;
                end
            end
            EVAL: begin
                if (enough) begin
                    balance_d = credit_q - price;
                    news_d    = (product_q == 2'b01);
                    choc_d    = (product_q == 2'b10);
                    juice_d   = (product_q == 2'b11);
                end
            end
            WAIT_EXTRA: begin
                if (cancel) begin
                    balance_d = credit_q;
                end else if (enough) begin
                    balance_d = credit_q - price;
                    news_d    = (product_q == 2'b01);
                    choc_d    = (product_q == 2'b10);
                    juice_d   = (product_q == 2'b11);
                end else if (topup_rise) begin
                    credit_d = topup_sat;
                end
            end
        endcase
    end

    assign news    = news_q;
    assign choc    = choc_q;
    assign juice   = juice_q;
    assign balance = balance_q;

endmodule

// File: tb/tb_ven_machine.sv
// Bench for ven_machine: directed vector table plus randomized
// traffic checked against a purchase-level reference model.
module tb_ven_machine;

    logic       clock;
    logic       reset;
    logic       news, choc, juice;
    logic [4:0] balance;
    logic [4:0] money;
    logic [1:0] select_product;
    logic [4:0] extra_cash;

    int tests;
    int fails;

    ven_machine dut (
        .clock          (clock),
        .reset          (reset),
        .news           (news),
        .choc           (choc),
        .juice          (juice),
        .balance        (balance),
        .money          (money),
        .select_product (select_product),
        .extra_cash     (extra_cash)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [4:0] mo;
        logic [1:0] se;
        logic [4:0] ex;
        logic [2:0] prod;
        logic [4:0] bal;
    } vec_t;

    vec_t tv[$];

    // Reference model: a purchase is in one of four phases
    // (0 waiting for a request, 1 judging, 2 short of credit, 3 handed out).
    int         m_phase;
    int         m_credit;
    int         m_item;
    int         m_last_mo;
    int         m_last_se;
    int         m_prev_ex;
    int         m_bal;
    logic [2:0] m_prod;

    function automatic int price_of(int item);
        return 5 * item;
    endfunction

    task automatic model_step(input logic rst, input int mo,
                              input int se, input int ex);
        int nphase;
        m_prod = 3'b000;
        if (rst) begin
            m_phase = 0; m_credit = 0; m_item = 0;
            m_last_mo = 0; m_last_se = 0; m_prev_ex = 0; m_bal = 0;
            return;
        end
        nphase = m_phase;
        if (m_phase == 0 || m_phase == 3) begin
            if (mo != 0 && se != 0 &&
                (mo != m_last_mo || se != m_last_se)) begin
                m_credit = mo; m_item = se;
                m_last_mo = mo; m_last_se = se;
                m_bal = 0; nphase = 1;
            end else begin
                if (mo == 0) begin
                    m_last_mo = 0; m_last_se = 0;
                end
                nphase = 0;
            end
        end else begin
            if (m_phase == 2 && se == 0) begin
                m_bal = m_credit; nphase = 0;
            end else if (m_credit >= price_of(m_item)) begin
                m_prod = 3'b100 >> (m_item - 1);
                m_bal = m_credit - price_of(m_item);
                nphase = 3;
            end else if (m_phase == 2 && ex != 0 && m_prev_ex == 0) begin
                m_credit = (m_credit + ex > 31) ? 31 : m_credit + ex;
            end else begin
                nphase = 2;
            end
        end
        m_prev_ex = ex;
        m_phase = nphase;
    endtask

    task automatic cyc(input logic rst, input logic [4:0] mo,
                       input logic [1:0] se, input logic [4:0] ex);
        reset = rst; money = mo; select_product = se; extra_cash = ex;
        model_step(rst, int'(mo), int'(se), int'(ex));
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic rst, input logic [4:0] mo,
                       input logic [1:0] se, input logic [4:0] ex,
                       input logic [2:0] prod, input logic [4:0] bal);
        vec_t v;
        v.rst = rst; v.mo = mo; v.se = se; v.ex = ex;
        v.prod = prod; v.bal = bal;
        tv.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; money = '0; select_product = '0; extra_cash = '0;
        m_prod = '0;
        model_step(1'b1, 0, 0, 0);

        // rst mo se ex {news,choc,juice} balance
        add(1, 7, 3, 9, 3'b000, 0);
        add(1, 7, 3, 9, 3'b000, 0);
        add(0, 0, 0, 0, 3'b000, 0);
        add(0, 5, 1, 0, 3'b000, 0);
        add(0, 5, 1, 0, 3'b100, 0);
        add(0, 5, 1, 0, 3'b000, 0);
        add(0, 5, 1, 0, 3'b000, 0);
        add(0, 5, 1, 0, 3'b000, 0);
        add(0, 20, 3, 0, 3'b000, 0);
        add(0, 20, 3, 0, 3'b001, 5);
        add(0, 20, 3, 0, 3'b000, 5);
        add(0, 20, 2, 0, 3'b000, 0);
        add(0, 20, 2, 0, 3'b010, 10);
        add(0, 0, 0, 0, 3'b000, 10);
        add(0, 5, 2, 0, 3'b000, 0);
        add(0, 5, 2, 0, 3'b000, 0);
        add(0, 5, 2, 5, 3'b000, 0);
        add(0, 5, 2, 5, 3'b010, 0);
        add(0, 5, 2, 0, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 0, 0, 3'b000, 5);
        add(0, 10, 1, 0, 3'b000, 0);
        add(0, 10, 1, 0, 3'b100, 5);
        add(0, 0, 0, 0, 3'b000, 5);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 31, 3'b000, 0);
        add(0, 5, 3, 31, 3'b001, 16);
        add(0, 0, 0, 0, 3'b000, 16);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 5, 3'b000, 0);
        add(0, 5, 3, 5, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 5, 3'b000, 0);
        add(0, 5, 3, 0, 3'b001, 0);
        add(0, 0, 0, 0, 3'b000, 0);
        add(0, 5, 2, 0, 3'b000, 0);
        add(0, 5, 2, 0, 3'b000, 0);
        add(0, 5, 0, 7, 3'b000, 5);
        add(0, 0, 0, 0, 3'b000, 5);
        add(0, 5, 3, 0, 3'b000, 0);
        add(0, 5, 3, 0, 3'b000, 0);
        add(1, 5, 3, 31, 3'b000, 0);
        add(0, 0, 0, 0, 3'b000, 0);
        add(0, 0, 0, 0, 3'b000, 0);

        foreach (tv[i]) begin
            cyc(tv[i].rst, tv[i].mo, tv[i].se, tv[i].ex);
            tests++;
            if ({news, choc, juice} !== tv[i].prod ||
                balance !== tv[i].bal) begin
                fails++;
                $display("FAIL vec%0d: got prod=%b bal=%0d want prod=%b bal=%0d",
                         i, {news, choc, juice}, balance,
                         tv[i].prod, tv[i].bal);
            end
        end

        begin
            logic       r;
            logic [4:0] mo, ex;
            logic [1:0] se;
            logic [4:0] picks [6];
            picks = '{5'd0, 5'd5, 5'd10, 5'd15, 5'd20, 5'd31};
            mo = 0; se = 0; ex = 0;
            for (int n = 0; n < 4000; n++) begin
                r = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 2) == 0) begin
                    mo = ($urandom_range(0, 3) == 0) ?
                         5'($urandom_range(0, 31)) :
                         picks[$urandom_range(0, 5)];
                    se = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 2) == 0)
                    ex = ($urandom_range(0, 1) == 0) ? 5'd0 :
                         5'($urandom_range(1, 31));
                cyc(r, mo, se, ex);
                tests++;
                if ({news, choc, juice} !== m_prod ||
                    balance !== 5'(m_bal)) begin
                    fails++;
                    $display("FAIL rand%0d: got prod=%b bal=%0d want prod=%b bal=%0d",
                             n, {news, choc, juice}, balance, m_prod, m_bal);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
